// File: rtl/pipe_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_share_arbiter                                                         |
// | Round-robin sharing of a fixed-latency valid-only pipeline, with tagged,   |
// | credit-protected response FIFO.                                            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pipe_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      pipe_in_valid,
  output logic [DATA_W-1:0]         pipe_in_data,
  input  logic                      pipe_out_valid,
  input  logic [DATA_W-1:0]         pipe_out_data,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [TAG_W-1:0]          rsp_tag,
  input  logic                      rsp_ready,
  output logic                      err_unexpected
);

  localparam int c_occ_w = $clog2(FIFO_DEPTH + 1);
  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_occ_w-1:0] c_depth    = c_occ_w'(FIFO_DEPTH);
  localparam logic [TAG_W-1:0]   c_last_req = TAG_W'(NUM_REQ - 1);
  localparam logic [c_ptr_w-1:0] c_last_ent = c_ptr_w'(FIFO_DEPTH - 1);

  logic [TAG_W-1:0]        r_ptr;
  logic [TAG_W-1:0]        w_win;
  logic                    w_found;
  logic                    w_issue;
  logic [c_occ_w-1:0]      r_occ;
  logic [LATENCY-1:0]      r_sh_vld;
  logic [TAG_W-1:0]        r_sh_tag [LATENCY];
  logic                    w_last_vld;
  logic [TAG_W-1:0]        w_last_tag;
  logic                    w_wr;
  logic                    w_pop;
  logic [TAG_W+DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]      r_wptr;
  logic [c_ptr_w-1:0]      r_rptr;
  logic [c_occ_w-1:0]      r_cnt;

  // Round-robin search starting at r_ptr, wrapping at NUM_REQ.
  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (!w_found && req_valid[v_idx]) begin
        w_found = 1'b1;
        w_win   = TAG_W'(v_idx);
      end
    end
  end

  assign w_issue       = rst_n && w_found && (r_occ < c_depth);
  assign pipe_in_valid = w_issue;
  assign pipe_in_data  = w_issue ? req_data[int'(w_win)*DATA_W +: DATA_W] : '0;

  always_comb begin
    req_ready = '0;
    if (w_issue) req_ready[w_win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       r_ptr <= '0;
    else if (w_issue) r_ptr <= (w_win == c_last_req) ? '0 : w_win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh_vld <= '0;
      for (int i = 0; i < LATENCY; i++) r_sh_tag[i] <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        r_sh_vld[i] <= r_sh_vld[i-1];
        r_sh_tag[i] <= r_sh_tag[i-1];
      end
      r_sh_vld[0] <= w_issue;
      r_sh_tag[0] <= w_win;
    end
  end

  assign w_last_vld = r_sh_vld[LATENCY-1];
  assign w_last_tag = w_last_vld ? r_sh_tag[LATENCY-1] : '0;

  // Credits normally make a full-FIFO write impossible; a stray result is dropped
  // rather than corrupting the head when no slot frees up this cycle.
  assign w_pop = rsp_valid && rsp_ready;
  assign w_wr  = rst_n && pipe_out_valid && ((r_cnt != c_depth) || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n)                          err_unexpected <= 1'b0;
    else if (pipe_out_valid != w_last_vld) err_unexpected <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else if (w_issue && !w_pop) begin
      r_occ <= r_occ + 1'b1;
    end else if (w_pop && !w_issue && (r_occ != '0)) begin
      r_occ <= r_occ - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {w_last_tag, pipe_out_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr)  r_wptr <= (r_wptr == c_last_ent) ? '0 : r_wptr + 1'b1;
      if (w_pop) r_rptr <= (r_rptr == c_last_ent) ? '0 : r_rptr + 1'b1;
      if (w_wr && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_wr) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign rsp_valid           = rst_n && (r_cnt != '0);
  assign {rsp_tag, rsp_data} = rsp_valid ? r_mem[r_rptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_pipe_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_share_arbiter                                                      |
// | Scoreboard bench: two instances (FIFO depth 4 and 2) on an x+1 pipeline.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_pipe_share_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid,  req_ready,  req_valid2, req_ready2;
  logic [127:0] req_data,   req_data2;
  logic         pin_v, pin_v2, pout_v, pout_v2;
  logic [31:0]  pin_d, pin_d2, pout_d, pout_d2;
  logic         rsp_valid, rsp_ready, rsp_valid2, rsp_ready2;
  logic [31:0]  rsp_data, rsp_data2;
  logic [1:0]   rsp_tag, rsp_tag2;
  logic         err, err2;
  logic         force_err;
  logic [31:0]  force_data;

  // Two-stage x+1 pipeline models
  logic        r_p1_v, r_p2_v, r_q1_v, r_q2_v;
  logic [31:0] r_p1_d, r_p2_d, r_q1_d, r_q2_d;

  logic [33:0] exp_q [$];
  logic [33:0] exp_q2 [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_issue2 = 0;
  int          n_pop2   = 0;

  always #5 clk = ~clk;

  pipe_share_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .pipe_in_valid(pin_v), .pipe_in_data(pin_d),
    .pipe_out_valid(pout_v), .pipe_out_data(pout_d), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
    .err_unexpected(err)
  );

  pipe_share_arbiter #(.FIFO_DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_data(req_data2),
    .req_ready(req_ready2), .pipe_in_valid(pin_v2), .pipe_in_data(pin_d2),
    .pipe_out_valid(pout_v2), .pipe_out_data(pout_d2), .rsp_valid(rsp_valid2),
    .rsp_data(rsp_data2), .rsp_tag(rsp_tag2), .rsp_ready(rsp_ready2),
    .err_unexpected(err2)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      r_p1_v <= 1'b0; r_p2_v <= 1'b0; r_q1_v <= 1'b0; r_q2_v <= 1'b0;
    end else begin
      r_p1_v <= pin_v;  r_p2_v <= r_p1_v;
      r_q1_v <= pin_v2; r_q2_v <= r_q1_v;
    end
    r_p1_d <= pin_d + 32'd1;  r_p2_d <= r_p1_d;
    r_q1_d <= pin_d2 + 32'd1; r_q2_d <= r_q1_d;
  end

  assign pout_v  = r_p2_v | force_err;
  assign pout_d  = force_err ? force_data : r_p2_d;
  assign pout_v2 = r_q2_v;
  assign pout_d2 = r_q2_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitors: every handshake pops and compares the oldest expectation
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rsp1_unexpected: got tag=%0d data=%0h, expected no response", rsp_tag, rsp_data);
      end else begin
        check("rsp1", {30'b0, rsp_tag, rsp_data}, {30'b0, exp_q.pop_front()});
      end
    end
    if (rsp_valid2 && rsp_ready2) begin
      n_pop2++;
      if (exp_q2.size() == 0) begin
        n_checks++;
        $display("FAIL rsp2_unexpected: got tag=%0d data=%0h, expected no response", rsp_tag2, rsp_data2);
      end else begin
        check("rsp2", {30'b0, rsp_tag2, rsp_data2}, {30'b0, exp_q2.pop_front()});
      end
    end
    if (rst_n && pout_v)
      check("no_overflow1", {63'b0, (u_dut.r_cnt == 3'd4) && !(rsp_valid && rsp_ready)}, 64'd0);
    if (rst_n && pout_v2)
      check("no_overflow2", {63'b0, (u_dut2.r_cnt == 2'd2) && !(rsp_valid2 && rsp_ready2)}, 64'd0);
  end

  // Instance 2 grants must rotate 0,1,2,3,... regardless of throttling
  always @(negedge clk) begin
    logic [1:0] t;
    if (rst_n && ((req_valid2 & req_ready2) != 4'b0)) begin
      t = 2'(n_issue2 % 4);
      check("grant2", {60'b0, req_ready2}, {60'b0, 4'b0001 << t});
      exp_q2.push_back({t, 32'(t) * 32'd10 + 32'd1});
      n_issue2++;
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = 4'hF; req_valid2 = 4'h0; rsp_ready = 1'b0; rsp_ready2 = 1'b0;
    force_err = 1'b0; force_data = 32'h0;
    req_data = '0; req_data2 = '0;
    for (int i = 0; i < 4; i++) req_data2[i*32 +: 32] = 32'(i * 10);
    step(); step();
    check("rst_req_ready", {60'b0, req_ready}, 64'd0);
    check("rst_pipe_in_valid", {63'b0, pin_v}, 64'd0);
    check("rst_rsp", {30'b0, rsp_valid, rsp_tag, rsp_data[30:0]}, 64'd0);
    req_valid = 4'h0;
    rst_n = 1'b1;
    step();
    check("idle_err", {63'b0, err}, 64'd0);

    // Single request from requester 2
    rsp_ready = 1'b1; req_valid = 4'b0100; req_data[2*32 +: 32] = 32'd5;
    #1;
    check("single_grant", {60'b0, req_ready}, 64'b0100);
    check("single_pipe_in", {31'b0, pin_v, pin_d}, {31'b0, 1'b1, 32'd5});
    exp_q.push_back({2'd2, 32'd6});
    step(); req_valid = 4'h0; #1;
    check("single_lat_t1", {63'b0, rsp_valid}, 64'd0);
    step();
    check("single_lat_t2", {63'b0, rsp_valid}, 64'd0);
    step();
    check("single_rsp", {29'b0, rsp_valid, rsp_tag, rsp_data}, {29'b0, 1'b1, 2'd2, 32'd6});
    step();
    check("single_drained", {63'b0, rsp_valid}, 64'd0);

    // Fairness from a fresh pointer
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'(i * 10);
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("fair_grant", {60'b0, req_ready}, {60'b0, 4'b0001 << (k % 4)});
      exp_q.push_back({2'(k % 4), 32'((k % 4) * 10 + 1)});
      step();
    end
    req_valid = 4'h0;
    repeat (5) step();

    // Backpressure: four credits, then nothing until a pop
    rsp_ready = 1'b0; req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_grant", {60'b0, req_ready}, {60'b0, 4'b0001 << k});
      exp_q.push_back({2'(k), 32'(k * 10 + 1)});
      step();
    end
    for (int k = 0; k < 6; k++) begin
      check("bp_stalled", {60'b0, req_ready}, 64'd0);
      step();
    end
    check("bp_head", {29'b0, rsp_valid, rsp_tag, rsp_data}, {29'b0, 1'b1, 2'd0, 32'd1});
    rsp_ready = 1'b1; #1;
    check("bp_pop_cycle_no_issue", {60'b0, req_ready}, 64'd0);
    step(); rsp_ready = 1'b0; #1;
    check("bp_one_issue", {60'b0, req_ready}, 64'b0001);
    exp_q.push_back({2'd0, 32'd1});
    step();
    check("bp_stalled_again", {60'b0, req_ready}, 64'd0);
    req_valid = 4'h0; rsp_ready = 1'b1;
    repeat (8) step();
    check("bp_err", {63'b0, err}, 64'd0);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two ops in flight and two buffered (pointer starts at 1 here)
    rsp_ready = 1'b0; req_valid = 4'hF;
    repeat (4) step();
    rst_n = 1'b0; #1;
    check("midrst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("midrst_req_ready", {60'b0, req_ready}, 64'd0);
    step();
    rst_n = 1'b1; req_valid = 4'h0; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("midrst_no_stale", {63'b0, rsp_valid}, 64'd0);
      step();
    end
    req_valid = 4'hF; #1;
    check("midrst_grant0", {60'b0, req_ready}, 64'b0001);
    exp_q.push_back({2'd0, 32'd1});
    step(); req_valid = 4'h0;
    repeat (5) step();

    // Stray pipeline result with nothing issued
    force_err = 1'b1; force_data = 32'h1234;
    exp_q.push_back({2'd0, 32'h1234});
    #1;
    check("err_before", {63'b0, err}, 64'd0);
    step(); force_err = 1'b0; #1;
    check("err_set", {63'b0, err}, 64'd1);
    repeat (4) step();
    check("err_sticky", {63'b0, err}, 64'd1);
    rst_n = 1'b0; step(); rst_n = 1'b1; #1;
    check("err_cleared", {63'b0, err}, 64'd0);

    // Depth-2 instance with toggling downstream ready
    req_valid2 = 4'hF;
    for (int k = 0; k < 24; k++) begin
      rsp_ready2 = (k % 2 == 0);
      step();
    end
    req_valid2 = 4'h0; rsp_ready2 = 1'b1;
    repeat (8) step();
    check("d2_progress", {63'b0, n_issue2 >= 6}, 64'd1);
    check("d2_all_returned", 64'(n_pop2), 64'(n_issue2));
    check("d2_queue_empty", 64'(exp_q2.size()), 64'd0);
    check("d2_err", {63'b0, err2}, 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
